pll_rst_seq: RTL and testbench

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_pkg.sv | 28 ++
 rtl/sync_ff.sv | 24 ++
 rtl/pll_rst_seq.sv | 131 +++++++++++++
 tb/tb_pll_rst_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared constants for the PLL reset sequencer: FSM state encoding and
// default timing parameters.
package pll_pkg;

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_FILTER    = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PLL_RST_CYCLES = 8;
    localparam int DEF_LOCK_FILTER    = 16;
    localparam int DEF_RST_HOLD       = 256;
    localparam int DEF_LOCK_TIMEOUT   = 65536;

    localparam int RELOCK_W = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous level signal.
// Clears to 0 on asynchronous reset; STAGES must be at least 2.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a filtered lock,
// holds the downstream reset, then releases it and watches for lock loss.
module pll_rst_seq
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int RST_HOLD       = DEF_RST_HOLD,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lock_i,
    output logic                pll_reset_o,
    output logic                rst_o,
    output logic                ready_o,
    output logic [RELOCK_W-1:0] relock_cnt_o
);

    // A single-flop synchronizer is never safe, so shallower requests are widened.
    localparam int SYNC   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_MX = max4(PLL_RST_CYCLES, LOCK_FILTER, RST_HOLD, LOCK_TIMEOUT);
    localparam int CNT_W  = (CNT_MX > 2) ? $clog2(CNT_MX) : 1;

    localparam logic [CNT_W-1:0] PRC_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] RH_LAST  = CNT_W'(RST_HOLD - 1);

    logic                lock_s;
    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [RELOCK_W-1:0] relock_nxt;

    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        return (v == '1) ? v : v + RELOCK_W'(1);
    endfunction

    sync_ff #(
        .STAGES (SYNC)
    ) u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (lock_i),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        relock_nxt = relock_cnt_o;
        case (state)
            ST_PLL_RST: begin
                if (cnt == PRC_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_FILTER;
                    cnt_nxt   = '0;
                end else if (cnt == LT_LAST) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_FILTER: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == LF_LAST) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            // Lock loss is tested first so it wins on the last HOLD cycle.
            ST_HOLD: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == RH_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt  = ST_WAIT_LOCK;
                    cnt_nxt    = '0;
                    relock_nxt = sat_inc(relock_cnt_o);
                end
            end
            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet track state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_PLL_RST;
            cnt          <= '0;
            pll_reset_o  <= 1'b1;
            rst_o        <= 1'b1;
            ready_o      <= 1'b0;
            relock_cnt_o <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            pll_reset_o  <= (state_nxt == ST_PLL_RST);
            rst_o        <= (state_nxt != ST_RUN);
            ready_o      <= (state_nxt == ST_RUN);
            relock_cnt_o <= relock_nxt;
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: one default instance for the full-length
// sequence and a shortened instance for timeout, boundary and saturation cases.
module tb_pll_rst_seq;
    import pll_pkg::*;

    localparam int LAT_DEF = 2 + 16 + 256 + 1;

    logic       clk;
    logic       reset, lock;
    logic       pll_reset, rst_s, ready;
    logic [7:0] relock;
    logic       reset2, lock2;
    logic       pll_reset2, rst2, ready2;
    logic [7:0] relock2;

    int n_chk;
    int n_pass;

    pll_rst_seq dut (
        .clk          (clk),
        .reset        (reset),
        .lock_i       (lock),
        .pll_reset_o  (pll_reset),
        .rst_o        (rst_s),
        .ready_o      (ready),
        .relock_cnt_o (relock)
    );

    pll_rst_seq #(
        .LOCK_TIMEOUT (100),
        .LOCK_FILTER  (2),
        .RST_HOLD     (4)
    ) dut2 (
        .clk          (clk),
        .reset        (reset2),
        .lock_i       (lock2),
        .pll_reset_o  (pll_reset2),
        .rst_o        (rst2),
        .ready_o      (ready2),
        .relock_cnt_o (relock2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int tmo;
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        reset2 = 1'b1;
        lock   = 1'b0;
        lock2  = 1'b0;
        repeat (3) step();

        check_eq("rst_pll_reset", pll_reset, 1);
        check_eq("rst_rst_o", rst_s, 1);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_relock", relock, 0);

        // Power-up sequence, lock 40 cycles after release
        reset = 1'b0;
        for (n = 1; n <= 50; n++) begin step(); if (!pll_reset) break; end
        check_eq("pll_pulse_width", n, 8);
        repeat (32) step();
        lock = 1'b1;
        for (n = 1; n <= 600; n++) begin step(); if (!rst_s) break; end
        check_eq("lock_to_rst_fall", n, LAT_DEF);
        check_eq("ready_same_edge", ready, 1);
        check_eq("relock_initial", relock, 0);

        // One-cycle lock drop in RUN
        repeat (5) step();
        lock = 1'b0;
        for (n = 1; n <= 20; n++) begin
            step();
            if (n == 1) lock = 1'b1;
            if (rst_s) break;
        end
        check_eq("drop_to_rst", n, 3);
        check_eq("drop_ready_low", ready, 0);
        check_eq("drop_relock", relock, 1);
        for (n = 1; n <= 600; n++) begin step(); if (!rst_s) break; end
        check_eq("relock_refall", n, LAT_DEF - 2);

        // Second drop, then async reset while in HOLD
        repeat (5) step();
        lock = 1'b0;
        step();
        lock = 1'b1;
        repeat (100) step();
        check_eq("hold_rst_o", rst_s, 1);
        check_eq("hold_relock", relock, 2);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_pll_reset", pll_reset, 1);
        check_eq("async_rst_o", rst_s, 1);
        check_eq("async_ready", ready, 0);
        check_eq("async_relock", relock, 0);
        lock = 1'b0;
        repeat (2) step();

        // Short lock glitch from WAIT_LOCK
        reset = 1'b0;
        for (n = 1; n <= 50; n++) begin step(); if (!pll_reset) break; end
        check_eq("pll_pulse_after_abort", n, 8);
        repeat (12) step();
        lock = 1'b1;
        repeat (5) step();
        lock = 1'b0;
        repeat (10) step();
        check_eq("glitch_state", dut.state, ST_WAIT_LOCK);
        check_eq("glitch_rst_o", rst_s, 1);
        check_eq("glitch_ready", ready, 0);
        check_eq("glitch_relock", relock, 0);
        check_eq("glitch_pll_reset", pll_reset, 0);
        repeat (300) step();
        check_eq("glitch_still_rst", rst_s, 1);

        // Lock timeout with LOCK_TIMEOUT=100
        reset2 = 1'b0;
        for (n = 1; n <= 50; n++) begin step(); if (!pll_reset2) break; end
        check_eq("to_pulse1", n, 8);
        for (n = 1; n <= 300; n++) begin step(); if (pll_reset2) break; end
        check_eq("to_gap1", n, 100);
        for (n = 1; n <= 50; n++) begin step(); if (!pll_reset2) break; end
        check_eq("to_pulse2", n, 8);
        for (n = 1; n <= 300; n++) begin step(); if (pll_reset2) break; end
        check_eq("to_gap2", n, 100);
        for (n = 1; n <= 50; n++) begin step(); if (!pll_reset2) break; end
        check_eq("to_pulse3", n, 8);

        // Lock loss on the last HOLD cycle
        lock2 = 1'b1;
        repeat (6) step();
        lock2 = 1'b0;
        step();
        lock2 = 1'b1;
        repeat (2) step();
        check_eq("bnd_state", dut2.state, ST_WAIT_LOCK);
        check_eq("bnd_ready", ready2, 0);
        check_eq("bnd_rst_o", rst2, 1);
        check_eq("bnd_relock", relock2, 0);
        for (n = 1; n <= 50; n++) begin step(); if (!rst2) break; end
        check_eq("bnd_recover", n, 7);

        // 300 lock losses in RUN
        tmo = 0;
        for (int i = 1; i <= 300; i++) begin
            lock2 = 1'b0;
            step();
            lock2 = 1'b1;
            for (n = 1; n <= 20; n++) begin if (!ready2) break; step(); end
            if (n > 20) tmo++;
            for (n = 1; n <= 50; n++) begin if (ready2) break; step(); end
            if (n > 50) tmo++;
            if (i == 1)   check_eq("sat_1", relock2, 1);
            if (i == 255) check_eq("sat_255", relock2, 255);
            if (i == 256) check_eq("sat_256", relock2, 255);
            if (i == 300) check_eq("sat_300", relock2, 255);
        end
        check_eq("sat_timeouts", tmo, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
